// File: rtl/mips_top_if.sv
// Data-memory bus between the mips_top datapath and its data memory.
// Word-indexed address; the byte offset is dropped by the datapath.
interface mips_top_if #(
    parameter int AW = 5
);
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic [31:0]   rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata
    );
endinterface

// File: rtl/mips_top.sv
// Single-cycle MIPS subset core with a fixed Fibonacci ROM,
// a 32x32 register file and a word-indexed data memory.
module mips_regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] RegData [0:31];

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : RegData[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : RegData[i_ra2];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            RegData[i_wa] <= i_wd;
        end
    end
endmodule

module mips_dmem #(
    parameter int DMEM_WORDS = 32
) (
    input logic       i_clk,
    mips_top_if.slave bus
);
    logic [31:0] Dmem [0:DMEM_WORDS-1];

    assign bus.rdata = Dmem[bus.addr];

    always_ff @(posedge i_clk) begin
        if (bus.we) begin
            Dmem[bus.addr] <= bus.wdata;
        end
    end
endmodule

module mips_top #(
    parameter int IMEM_WORDS = 32,
    parameter int DMEM_WORDS = 32
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam int PROG_LEN = 8;

    localparam logic [31:0] ROM_PROG [0:PROG_LEN-1] = '{
        32'h2008_0000,
        32'h2009_0001,
        32'h0109_5020,
        32'h0120_4020,
        32'h0140_4820,
        32'hAD69_0000,
        32'h216B_0004,
        32'h0800_0002
    };

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    logic [31:0]    r_pc;
    logic [31:0]    w_pc_plus4;
    logic [31:0]    w_pc_next;
    logic [31:0]    w_br_tgt;
    logic [31:0]    w_jmp_tgt;
    logic [IAW-1:0] w_iidx;
    logic [31:0]    w_instr;
    logic [5:0]     w_op;
    logic [5:0]     w_funct;
    logic [4:0]     w_rs;
    logic [4:0]     w_rt;
    logic [4:0]     w_rd;
    logic [31:0]    w_imm;
    logic [31:0]    w_rd1;
    logic [31:0]    w_rd2;
    logic [31:0]    w_alu_b;
    logic [31:0]    w_alu_y;
    logic [31:0]    w_wb;
    logic [4:0]     w_wa;

    logic    w_reg_we;
    logic    w_dst_rd;
    logic    w_use_imm;
    logic    w_mem_we;
    logic    w_mem_rd;
    logic    w_beq;
    logic    w_jmp;
    alu_op_e w_alu_op;

    mips_top_if #(.AW(DAW)) u_dbus ();

    // Fetch: words past the program read as NOPs.
    assign w_iidx = r_pc[IAW+1:2];

    always_comb begin
        w_instr = 32'd0;
        if (w_iidx < IAW'(PROG_LEN)) begin
            w_instr = ROM_PROG[w_iidx[2:0]];
        end
    end

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_funct = w_instr[5:0];
    assign w_imm   = {{16{w_instr[15]}}, w_instr[15:0]};

    // Anything not recognised leaves every control at its NOP default.
    always_comb begin
        w_reg_we  = 1'b0;
        w_dst_rd  = 1'b0;
        w_use_imm = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_rd  = 1'b0;
        w_beq     = 1'b0;
        w_jmp     = 1'b0;
        w_alu_op  = ALU_ADD;
        unique case (w_op)
            OP_RTYPE: begin
                if (w_instr[10:6] == 5'd0) begin
                    unique case (w_funct)
                        FN_ADD: begin
                            w_reg_we = 1'b1;
                            w_dst_rd = 1'b1;
                            w_alu_op = ALU_ADD;
                        end
                        FN_SUB: begin
                            w_reg_we = 1'b1;
                            w_dst_rd = 1'b1;
                            w_alu_op = ALU_SUB;
                        end
                        FN_AND: begin
                            w_reg_we = 1'b1;
                            w_dst_rd = 1'b1;
                            w_alu_op = ALU_AND;
                        end
                        FN_OR: begin
                            w_reg_we = 1'b1;
                            w_dst_rd = 1'b1;
                            w_alu_op = ALU_OR;
                        end
                        FN_SLT: begin
                            w_reg_we = 1'b1;
                            w_dst_rd = 1'b1;
                            w_alu_op = ALU_SLT;
                        end
                        default: ;
                    endcase
                end
            end
            OP_ADDI: begin
                w_reg_we  = 1'b1;
                w_use_imm = 1'b1;
            end
            OP_LW: begin
                w_reg_we  = 1'b1;
                w_use_imm = 1'b1;
                w_mem_rd  = 1'b1;
            end
            OP_SW: begin
                w_mem_we  = 1'b1;
                w_use_imm = 1'b1;
            end
            OP_BEQ:  w_beq = 1'b1;
            OP_J:    w_jmp = 1'b1;
            default: ;
        endcase
    end

    mips_regfile u_Register (
        .i_clk (clk),
        .i_we  (w_reg_we & ~rst),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_wa  (w_wa),
        .i_wd  (w_wb),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_alu_b = w_use_imm ? w_imm : w_rd2;

    always_comb begin
        w_alu_y = 32'd0;
        unique case (w_alu_op)
            ALU_ADD: w_alu_y = w_rd1 + w_alu_b;
            ALU_SUB: w_alu_y = w_rd1 - w_alu_b;
            ALU_AND: w_alu_y = w_rd1 & w_alu_b;
            ALU_OR:  w_alu_y = w_rd1 | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
            default: w_alu_y = 32'd0;
        endcase
    end

    assign u_dbus.addr  = w_alu_y[DAW+1:2];
    assign u_dbus.wdata = w_rd2;
    assign u_dbus.we    = w_mem_we & ~rst;

    mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_Data_memory (
        .i_clk (clk),
        .bus   (u_dbus.slave)
    );

    assign w_wb = w_mem_rd ? u_dbus.rdata : w_alu_y;
    assign w_wa = w_dst_rd ? w_rd : w_rt;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_tgt   = w_pc_plus4 + {w_imm[29:0], 2'b00};
    assign w_jmp_tgt  = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jmp) begin
            w_pc_next = w_jmp_tgt;
        end else if (w_beq && (w_rd1 == w_rd2)) begin
            w_pc_next = w_br_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end
endmodule

// File: tb/tb_mips_top.sv
// Bench for mips_top: expected architectural state is queued per
// edge and compared against the register file, memory and PC.
module tb_mips_top;
    logic clk;
    logic rst;

    typedef struct {
        int unsigned at;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_chk;
    int unsigned n_err;
    int unsigned cnt;

    mips_top dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #(20 * 5000);
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] fib(input int n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd1;
        b = 32'd1;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic logic [31:0] peek(input int kind, input int idx);
        case (kind)
            0:       return dut.u_Register.RegData[idx];
            1:       return dut.u_Data_memory.Dmem[idx];
            default: return dut.r_pc;
        endcase
    endfunction

    task automatic push(input int unsigned at, input int kind,
                        input int idx, input logic [31:0] val);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic zero_state();
        for (int i = 0; i < 32; i++) begin
            dut.u_Register.RegData[i] = 32'd0;
            dut.u_Data_memory.Dmem[i] = 32'd0;
        end
    endtask

    // Edges are numbered from 1 at the first edge with rst=0.
    task automatic run(input string ph, input int unsigned n);
        int i;
        string tag;
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            cnt++;
            chk({ph, "_r0"}, dut.u_Register.RegData[0], 32'd0);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].at == cnt) begin
                    tag = $sformatf("%s_e%0d_%s%0d", ph, cnt,
                                    sb[i].kind == 0 ? "reg" :
                                    sb[i].kind == 1 ? "mem" : "pc",
                                    sb[i].idx);
                    chk(tag, peek(sb[i].kind, sb[i].idx), sb[i].val);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
        chk({ph, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        zero_state();

        @(posedge clk);
        #1;
        chk("a_pc_rst0", dut.r_pc, 32'd0);
        @(posedge clk);
        #1;
        chk("a_pc_rst1", dut.r_pc, 32'd0);

        push(2, 0, 9, 32'd1);
        push(2, 0, 8, 32'd0);
        for (int k = 0; k < 10; k++) push(5 + 6 * k, 0, 9, fib(k + 2));
        for (int k = 0; k < 5; k++) push(6 + 6 * k, 1, k, fib(k + 2));
        push(31, 0, 11, 32'd20);
        for (int j = 0; j < 7; j++) begin
            push(8 + j, 2, 0, (j < 6) ? 32'(8 + 4 * j) : 32'd8);
        end
        rst = 1'b0;
        run("a", 60);

        rst = 1'b1;
        zero_state();
        @(posedge clk);
        #1;
        chk("b_pc_rst", dut.r_pc, 32'd0);
        rst = 1'b0;
        push(24, 0, 11, 32'd12);
        push(24, 1, 3, fib(5));
        run("b_pre", 24);

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("b_pc_mid", dut.r_pc, 32'd0);
        chk("b_keep9", dut.u_Register.RegData[9], fib(5));
        chk("b_keep11", dut.u_Register.RegData[11], 32'd12);
        rst = 1'b0;
        push(2, 0, 9, 32'd1);
        push(2, 0, 8, 32'd0);
        push(6, 1, 3, 32'd1);
        push(7, 0, 11, 32'd16);
        push(8, 1, 2, fib(4));
        run("b_post", 8);

        rst = 1'b1;
        zero_state();
        dut.u_Register.RegData[11] = 32'd124;
        @(posedge clk);
        #1;
        chk("c_pc_rst", dut.r_pc, 32'd0);
        rst = 1'b0;
        push(6, 1, 31, 32'd1);
        push(7, 0, 11, 32'd128);
        push(11, 1, 0, 32'd0);
        push(12, 1, 0, 32'd2);
        push(12, 1, 1, 32'd0);
        run("c", 13);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
